uart_rx_fifo: RTL and testbench

//  UART 8N1 receiver with a small receive FIFO. Consumes the synchronised rx

---
 rtl/uart_rx_fifo_if.sv | 11 +
 rtl/uart_rx_fifo.sv | 108 ++++++++++
 tb/tb_uart_rx_fifo.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: pop-side bus between the receive FIFO and its consumer.
interface uart_rx_fifo_if;
    logic       rd;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overflow;
    logic       clear_err;
    modport master (output rd, clear_err, input data_out, data_valid, frame_err, overflow);
    modport slave (input rd, clear_err, output data_out, data_valid, frame_err, overflow);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO with sticky error flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 12,
    parameter int FIFO_ADDR    = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    uart_rx_fifo_if.slave bus
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 2 ** FIFO_ADDR;
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FIFO_ADDR:0] DEPTH_N = DEPTH[FIFO_ADDR:0];

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;

    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0] bit_idx, bit_d;
    logic [7:0] shift, shift_d;
    logic push, push_d, ferr_set;
    logic [7:0] mem [DEPTH];
    logic [FIFO_ADDR-1:0] wp, rp;
    logic [FIFO_ADDR:0] count;
    logic do_pop, do_push, ovf_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            push    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            shift   <= shift_d;
            push    <= push_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt + 1'b1;
        bit_d    = bit_idx;
        shift_d  = shift;
        push_d   = 1'b0;
        ferr_set = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx) state_d = ST_START;
            end
            ST_START: if (cnt == HALF_LAST) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (cnt == FULL_LAST) begin
                cnt_d   = '0;
                shift_d = {rx, shift[7:1]};
                bit_d   = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_d = ST_STOP;
            end
            ST_STOP: if (cnt == FULL_LAST) begin
                cnt_d    = '0;
                push_d   = rx;
                ferr_set = !rx;
                state_d  = rx ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pop in the push cycle frees the slot, so a full FIFO still accepts the byte.
    assign do_pop  = bus.rd && count != '0;
    assign do_push = push && (count != DEPTH_N || do_pop);
    assign ovf_set = push && count == DEPTH_N && !do_pop;

    always_ff @(posedge clk)
        if (do_push) mem[wp] <= shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp            <= '0;
            rp            <= '0;
            count         <= '0;
            bus.frame_err <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count         <= count + {{FIFO_ADDR{1'b0}}, do_push} - {{FIFO_ADDR{1'b0}}, do_pop};
            bus.frame_err <= ferr_set ? 1'b1 : bus.clear_err ? 1'b0 : bus.frame_err;
            bus.overflow  <= ovf_set ? 1'b1 : bus.clear_err ? 1'b0 : bus.overflow;
        end
    end

    assign bus.data_valid = count != '0;
    assign bus.data_out   = bus.data_valid ? mem[rp] : 8'h00;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and random UART frames checked against a queue-based model.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] q[$];
    logic m_ferr = 1'b0;
    logic m_ovf = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo_if bus ();
    uart_rx_fifo #(.CLKS_PER_BIT(12), .FIFO_ADDR(2)) dut (.clk(clk), .reset(reset), .rx(rx), .bus(bus.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Frame starts at a negedge; edge T0 is the next posedge, stop sample at T0+114.
    task automatic send_byte(input logic [7:0] b, input logic stop, input bit chk_lat, input bit pop_on_push);
        logic [9:0] fr;
        bit popped;
        fr = {stop, b, 1'b0};
        popped = 1'b0;
        for (int j = 0; j < 10; j++) begin
            rx = fr[j];
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (j * 12 + c + 1 == 115) begin
                    if (chk_lat) chk("lat_before", 32'(bus.data_valid), 0);
                    if (pop_on_push && q.size() > 0) begin
                        chk("pp_head", 32'(bus.data_out), 32'(q[0]));
                        bus.rd = 1'b1;
                        popped = 1'b1;
                    end
                end
                if (j * 12 + c + 1 == 116) begin
                    if (chk_lat) chk("lat_after", 32'(bus.data_valid), 1);
                    bus.rd = 1'b0;
                end
            end
        end
        if (!stop) m_ferr = 1'b1;
        else if (popped) begin
            void'(q.pop_front());
            q.push_back(b);
        end else if (q.size() == 4) m_ovf = 1'b1;
        else q.push_back(b);
    endtask

    task automatic pop_chk(input string tag);
        @(negedge clk);
        if (q.size() > 0) begin
            chk({tag, "_dv"}, 32'(bus.data_valid), 1);
            chk({tag, "_data"}, 32'(bus.data_out), 32'(q[0]));
            void'(q.pop_front());
        end
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        chk({tag, "_dv_next"}, 32'(bus.data_valid), 32'(q.size() > 0));
    endtask

    task automatic flags_chk(input string tag);
        chk({tag, "_ferr"}, 32'(bus.frame_err), 32'(m_ferr));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(m_ovf));
        chk({tag, "_dv"}, 32'(bus.data_valid), 32'(q.size() > 0));
    endtask

    task automatic clear_flags();
        bus.clear_err = 1'b1;
        @(negedge clk);
        bus.clear_err = 1'b0;
        m_ferr = 1'b0;
        m_ovf = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        bus.rd = 1'b0;
        bus.clear_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dv", 32'(bus.data_valid), 0);
        chk("rst_data", 32'(bus.data_out), 0);
        chk("rst_ferr", 32'(bus.frame_err), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        reset = 1'b1;
        idle(3);

        send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
        idle(2);
        pop_chk("t1");
        flags_chk("t1");

        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        flags_chk("t2_glitch");

        send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        flags_chk("t3_break");
        idle(5);
        send_byte(8'h55, 1'b1, 1'b0, 1'b0);
        idle(2);
        flags_chk("t3_after");
        pop_chk("t3_pop");
        clear_flags();
        flags_chk("t3_clear");

        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1, 1'b0, 1'b0);
            idle(2);
        end
        flags_chk("t4_ovf");
        for (int i = 0; i < 4; i++) pop_chk("t4_pop");
        clear_flags();
        flags_chk("t4_clear");

        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i), 1'b1, 1'b0, 1'b0);
            idle(2);
        end
        send_byte(8'h05, 1'b1, 1'b0, 1'b1);
        idle(2);
        flags_chk("t5_nov");
        for (int i = 0; i < 4; i++) pop_chk("t5_pop");

        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (24) @(negedge clk);
        rx = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        m_ferr = 1'b0;
        m_ovf = 1'b0;
        idle(5);
        flags_chk("t6_rst");
        send_byte(8'h12, 1'b1, 1'b0, 1'b0);
        idle(2);
        pop_chk("t6_pop");
        clear_flags();
        flags_chk("t6_clear");

        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            logic stop;
            b = 8'($urandom);
            stop = $urandom_range(0, 7) != 0;
            send_byte(b, stop, 1'b0, q.size() == 4 && $urandom_range(0, 1) == 1);
            if (!stop) repeat ($urandom_range(0, 30)) @(negedge clk);
            idle(2);
            flags_chk("rnd");
            repeat ($urandom_range(0, 2)) pop_chk("rnd_pop");
            if ($urandom_range(0, 3) == 0) begin
                clear_flags();
                flags_chk("rnd_clear");
            end
        end
        while (q.size() > 0) pop_chk("drain");
        pop_chk("empty_rd");
        flags_chk("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
